reg_bank16: RTL and testbench
=============================

Name: reg_bank16

Overview:
- 16 x 16-bit architectural register bank for the top-level processor.
- Sits directly upstream of the 16-to-1 16-bit operand multiplexer. Exposes all 16 registers on one flattened bus; the mux slices it into M0..M15 and selects one with its 4-bit select.
- R15 is the program counter, with its own increment/load controls.
- R0 reads as zero when ZERO_R0=1.
- A per-register busy scoreboard lets the control FSM reserve a destination for a multi-cycle result (e.g. a memory load) and stall until it is written.

Parameters:
- RESET_PC, 16'h0000, value loaded into R15 on reset.
- ZERO_R0, 1, 1 = R0 hardwired to 0 and writes/reservations to R0 ignored; 0 = R0 is an ordinary register.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- we  in  1  general write enable.
- wa  in  4  write address.
- wd  in  16  write data.
- pc_inc  in  1  advance R15 by 1.
- pc_load  in  1  load R15 from pc_val (branch/jump).
- pc_val  in  16  branch target.
- rsv  in  1  reserve request: set busy[rsv_a].
- rsv_a  in  4  register to reserve.
- regs  out  256  register contents, R[n] at bits [16n+15:16n].
- pc  out  16  copy of R15, same as regs[255:240].
- busy  out  16  scoreboard; busy[n]=1 means R[n] has a result pending.
- any_busy  out  1  OR of busy.

Behaviour:
- Reset (rst_n low, asynchronous):
  - R0..R14 = 0, R15 = RESET_PC, busy = 0.
  - Holds while rst_n is low; the first update is on the first rising clk after deassertion.
  - Reset mid-operation discards all pending reservations and writes.
- Outputs are direct register Q values. No combinational path from inputs to outputs. A write issued in cycle N is visible on regs in cycle N+1. No internal write-to-read bypass.
- General write: on a clk edge with we=1, R[wa] <= wd. Exception: when wa=0 and ZERO_R0=1 the write is dropped and R0 stays 0.
- R15 update priority, per edge, highest first:
  1. pc_load=1: R15 <= pc_val.
  2. we=1 with wa=15: R15 <= wd.
  3. pc_inc=1: R15 <= R15 + 1, modulo 2^16, so 16'hFFFF wraps to 16'h0000.
  4. Otherwise hold.
- Lower-priority R15 sources in the same cycle are discarded, not deferred.
- Scoreboard, per register n, per edge:
  - Set when rsv=1 and rsv_a=n.
  - Cleared when a write lands on n: we=1 with wa=n, or pc_load for n=15.
  - Reserve and write to the same n in the same cycle: data is written and busy[n] ends at 1 (the new reservation wins).
  - Reserving an already-busy register leaves it at 1, no error.
  - pc_inc does not clear busy[15].
  - With ZERO_R0=1, busy[0] is constant 0.
- Writes are accepted regardless of busy state. Stalling is the control FSM's job, using busy/any_busy.
- any_busy is the combinational OR of the registered busy bits.
- No X propagation: every register has a defined reset value.

Test Plan:
- Reset: rst_n=0 with RESET_PC=16'h0100 -> regs all 0 except R15=16'h0100, busy=0, any_busy=0. Assert rst_n=0 asynchronously mid-cycle after writes -> same values immediately, before the next clk edge.
- Write/readback: we=1, wa=5, wd=16'hBEEF for one cycle -> regs[95:80]=16'hBEEF from the next cycle. Then wa=0, wd=16'h1234 with ZERO_R0=1 -> regs[15:0] stays 16'h0000.
- PC: R15=16'hFFFE, pc_inc=1 for 3 cycles -> pc = FFFF, 0000, 0001.
- PC priority: pc_load=1, pc_val=16'h0040, we=1, wa=15, wd=16'h0999, pc_inc=1 in the same cycle -> pc=16'h0040. Next cycle, only we to 15 with wd=16'h0999 and pc_inc=1 -> pc=16'h0999.
- Scoreboard: rsv=1, rsv_a=3 -> busy=16'h0008, any_busy=1. Two idle cycles -> unchanged. we=1, wa=3, wd=16'h0007 -> busy=0, R3=7. Then rsv and we to R3 with wd=16'h0009 in the same cycle -> R3=9, busy[3]=1.
- Reset during reservation: busy=16'h8008, then pulse rst_n low -> busy=0, pc=RESET_PC; normal writes resume after deassertion.

Source files
------------

// File: rtl/reg_bank16_if.sv
// reg_bank16_if: bus bundle between the control path and the register bank.
//   master : drives write port (we/wa/wd), PC controls (pc_inc/pc_load/pc_val)
//            and reservation requests (rsv/rsv_a); observes bank state.
//   slave  : the register bank; exposes regs (R[n] at [16n+15:16n]), pc,
//            busy scoreboard and any_busy.
interface reg_bank16_if;
  logic         we;
  logic [3:0]   wa;
  logic [15:0]  wd;
  logic         pc_inc;
  logic         pc_load;
  logic [15:0]  pc_val;
  logic         rsv;
  logic [3:0]   rsv_a;
  logic [255:0] regs;
  logic [15:0]  pc;
  logic [15:0]  busy;
  logic         any_busy;

  modport master (
    output we, wa, wd, pc_inc, pc_load, pc_val, rsv, rsv_a,
    input  regs, pc, busy, any_busy
  );

  modport slave (
    input  we, wa, wd, pc_inc, pc_load, pc_val, rsv, rsv_a,
    output regs, pc, busy, any_busy
  );
endinterface

// File: rtl/reg_bank16.sv
// reg_bank16: 16 x 16-bit architectural register bank with busy scoreboard.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset (R15 <- RESET_PC, rest and busy <- 0)
//   bus    : reg_bank16_if.slave (write port, PC controls, reservations,
//            flattened register outputs, busy/any_busy)
// R15 is the PC: pc_load beats a general write to 15, which beats pc_inc.
// With ZERO_R0=1, R0 and busy[0] are constant zero.
// All outputs are register Q values; there is no write-to-read bypass.

// One register plus its scoreboard bit.
module reg_bank16_cell #(
  parameter logic [15:0] RST_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld,
  input  logic [15:0] d,
  input  logic        set,
  input  logic        clr,
  output logic [15:0] q,
  output logic        b
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
      b <= 1'b0;
    end else begin
      if (ld) q <= d;
      // a reservation landing together with a write wins: result still pending
      b <= set | (b & ~clr);
    end
  end
endmodule

module reg_bank16 #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter bit          ZERO_R0  = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  reg_bank16_if.slave   bus
);
  logic [15:0][15:0] q;
  logic [15:0]       b;

  for (genvar n = 0; n < 16; n++) begin : g_lane
    if (n == 0 && ZERO_R0) begin : g_zero
      assign q[n] = '0;
      assign b[n] = 1'b0;
    end else begin : g_reg
      logic        hit;
      logic        ld;
      logic        clr;
      logic [15:0] d;
      assign hit = bus.we && (bus.wa == 4'(n));
      if (n == 15) begin : g_pc
        // pc_inc only advances; it is not a result write so busy is kept
        assign ld  = bus.pc_load | hit | bus.pc_inc;
        assign d   = bus.pc_load ? bus.pc_val :
                     hit         ? bus.wd     : q[15] + 16'd1;
        assign clr = bus.pc_load | hit;
      end else begin : g_gp
        assign ld  = hit;
        assign d   = bus.wd;
        assign clr = hit;
      end
      reg_bank16_cell #(.RST_VAL(n == 15 ? RESET_PC : 16'h0000)) u_cell (
        .clk   (clk),
        .rst_n (rst_n),
        .ld    (ld),
        .d     (d),
        .set   (bus.rsv && (bus.rsv_a == 4'(n))),
        .clr   (clr),
        .q     (q[n]),
        .b     (b[n])
      );
    end
  end

  assign bus.regs     = q;
  assign bus.pc       = q[15];
  assign bus.busy     = b;
  assign bus.any_busy = |b;
endmodule

// File: tb/tb_reg_bank16.sv
// Self-checking bench for reg_bank16 (RESET_PC=16'h0100, ZERO_R0=1).
// A behavioural model of the register file is compared against the DUT on
// every falling clock edge; directed literal checks pin the model.
module tb_reg_bank16;
  localparam logic [15:0] RPC = 16'h0100;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  bit   cmp_en;

  reg_bank16_if bus ();

  reg_bank16 #(.RESET_PC(RPC), .ZERO_R0(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [15:0] mr [16];
  logic [15:0] mbusy;

  function automatic logic [15:0] next_pc(input logic [15:0] cur);
    if (bus.pc_load)                     return bus.pc_val;
    else if (bus.we && bus.wa == 4'd15)  return bus.wd;
    else if (bus.pc_inc)                 return cur + 16'd1;
    else                                 return cur;
  endfunction

  function automatic logic [15:0] next_busy(input logic [15:0] cur);
    logic [15:0] nb;
    nb = cur;
    for (int n = 0; n < 16; n++) begin
      if (bus.we && int'(bus.wa) == n) nb[n] = 1'b0;
      if (n == 15 && bus.pc_load)      nb[n] = 1'b0;
      if (bus.rsv && int'(bus.rsv_a) == n) nb[n] = 1'b1;
    end
    nb[0] = 1'b0;
    return nb;
  endfunction

  function automatic logic [255:0] flat();
    logic [255:0] f;
    for (int n = 0; n < 16; n++) f[16*n +: 16] = mr[n];
    return f;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < 15; n++) mr[n] <= 16'h0000;
      mr[15] <= RPC;
      mbusy  <= 16'h0000;
    end else begin
      for (int n = 1; n < 15; n++)
        if (bus.we && int'(bus.wa) == n) mr[n] <= bus.wd;
      mr[15] <= next_pc(mr[15]);
      mbusy  <= next_busy(mbusy);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      checks++;
      if (bus.regs !== flat() || bus.pc !== mr[15] || bus.busy !== mbusy ||
          bus.any_busy !== (|mbusy)) begin
        errors++;
        $display("FAIL model t=%0t regs=%h exp=%h pc=%h exp=%h busy=%h exp=%h any=%b",
                 $time, bus.regs, flat(), bus.pc, mr[15], bus.busy, mbusy, bus.any_busy);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.we = 0; bus.wa = 0; bus.wd = 0; bus.pc_inc = 0; bus.pc_load = 0;
    bus.pc_val = 0; bus.rsv = 0; bus.rsv_a = 0;
  endtask

  // advance one edge; returns 1 ns after it with outputs settled
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [255:0] rst_img;
    checks = 0; errors = 0; cmp_en = 0;
    rst_img = '0;
    rst_img[255:240] = RPC;
    idle();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    step(); step();
    chk("reset_regs", bus.regs, rst_img);
    chk("reset_busy", {bus.any_busy, bus.busy}, '0);
    rst_n = 1'b1;
    cmp_en = 1;
    step();
    chk("reset_hold_pc", bus.pc, RPC);

    // write / readback
    bus.we = 1; bus.wa = 5; bus.wd = 16'hBEEF;
    step();
    chk("write_r5", bus.regs[95:80], 16'hBEEF);
    bus.wa = 0; bus.wd = 16'h1234;
    step();
    chk("r0_zero", bus.regs[15:0], 16'h0000);
    idle();

    // PC wrap
    bus.pc_load = 1; bus.pc_val = 16'hFFFE;
    step();
    chk("pc_load", bus.pc, 16'hFFFE);
    idle(); bus.pc_inc = 1;
    step(); chk("pc_inc1", bus.pc, 16'hFFFF);
    step(); chk("pc_inc2", bus.pc, 16'h0000);
    step(); chk("pc_inc3", bus.pc, 16'h0001);

    // PC priority
    bus.pc_load = 1; bus.pc_val = 16'h0040; bus.we = 1; bus.wa = 15;
    bus.wd = 16'h0999; bus.pc_inc = 1;
    step(); chk("pc_prio_load", bus.pc, 16'h0040);
    bus.pc_load = 0;
    step(); chk("pc_prio_we", bus.pc, 16'h0999);
    chk("pc_alias", bus.regs[255:240], 16'h0999);
    idle();

    // scoreboard
    bus.rsv = 1; bus.rsv_a = 3;
    step(); chk("rsv3", {bus.any_busy, bus.busy}, {1'b1, 16'h0008});
    idle();
    step(); step(); chk("rsv3_hold", bus.busy, 16'h0008);
    bus.we = 1; bus.wa = 3; bus.wd = 16'h0007;
    step(); chk("clr3_busy", {bus.any_busy, bus.busy}, '0);
    chk("clr3_data", bus.regs[63:48], 16'h0007);
    bus.wd = 16'h0009; bus.rsv = 1; bus.rsv_a = 3;
    step(); chk("rsv_we_data", bus.regs[63:48], 16'h0009);
    chk("rsv_we_busy", bus.busy, 16'h0008);
    idle(); bus.rsv = 1; bus.rsv_a = 15;
    step(); chk("rsv15", bus.busy, 16'h8008);
    bus.rsv_a = 0;
    step(); chk("rsv0_ignored", bus.busy, 16'h8008);
    idle(); bus.pc_inc = 1;
    step(); chk("inc_keeps_busy", bus.busy, 16'h8008);
    idle();

    // async reset mid-cycle
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_regs", bus.regs, rst_img);
    chk("async_rst_busy", {bus.any_busy, bus.busy}, '0);
    #1 rst_n = 1'b1;
    bus.we = 1; bus.wa = 7; bus.wd = 16'h1111;
    step(); chk("post_rst_write", bus.regs[127:112], 16'h1111);
    idle();

    // randomized traffic checked by the model
    for (int i = 0; i < 3000; i++) begin
      bus.we      = $urandom_range(0, 1) == 1;
      bus.wa      = 4'($urandom);
      bus.wd      = 16'($urandom);
      bus.pc_inc  = $urandom_range(0, 2) != 0;
      bus.pc_load = $urandom_range(0, 7) == 0;
      bus.pc_val  = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      bus.rsv     = $urandom_range(0, 2) == 0;
      bus.rsv_a   = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      step();
    end
    idle();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
